// File: rtl/module_recir_activador_pkg.sv
// Shared types and defaults for the recirculation receive-side activator.
// Holds the FSM state encoding, word width and default training parameters.
package module_recir_activador_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] DEF_TRAIN_PATTERN = 32'hBCBC_BCBC;
  localparam int DEF_TRAIN_COUNT = 4;
  localparam int DEF_LOSS_COUNT  = 8;

  // 2'd3 is left unassigned on purpose; the FSM folds it back to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAIN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/module_recir_activador_if.sv
// Returned-word stream in, forwarded stream plus link status out.
// The slave side is the activator; the master side drives words and observes status.
interface module_recir_activador_if;
  import module_recir_activador_pkg::*;

  logic              valid_in_Ret;
  logic [WORD_W-1:0] data_in_Ret;
  logic              active;
  logic              valid_out_Rx;
  logic [WORD_W-1:0] data_out_Rx;
  logic [1:0]        state_Rx;
  logic [7:0]        err_count;

  modport slave (
    input  valid_in_Ret, data_in_Ret,
    output active, valid_out_Rx, data_out_Rx, state_Rx, err_count
  );

  modport master (
    output valid_in_Ret, data_in_Ret,
    input  active, valid_out_Rx, data_out_Rx, state_Rx, err_count
  );

endinterface

// File: rtl/module_rx_flop.sv
// Output stage: data + valid register with load enable.
// valid follows load each cycle; data only changes on a load and otherwise holds.
module module_rx_flop #(
  parameter int W = 32
) (
  input  logic         clk_2f,
  input  logic         reset_L,
  input  logic         load,
  input  logic [W-1:0] data_d,
  output logic         valid_q,
  output logic [W-1:0] data_q
);

  // NOTE: data_q is a plain output register, not storage, so it is reset along with valid.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= load;
      if (load) data_q <= data_d;
    end
  end

endmodule

// File: rtl/module_recir_activador.sv
// Receive-side activator: trains on a fixed pattern, then forwards words and drives `active`.
// Define RECIR_ERR_COUNT_EN to keep a saturating training-mismatch counter on err_count.
module module_recir_activador
  import module_recir_activador_pkg::*;
#(
  parameter logic [WORD_W-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
  parameter int                TRAIN_COUNT   = DEF_TRAIN_COUNT,
  parameter int                LOSS_COUNT    = DEF_LOSS_COUNT
) (
  input logic                      clk_2f,
  input logic                      reset_L,
  module_recir_activador_if.slave  bus
);

  localparam int TW = $clog2(TRAIN_COUNT + 1);
  localparam int IW = $clog2(LOSS_COUNT + 1);
  // Compare against count-1 so the counters never have to hold the terminal value.
  localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_COUNT - 1);
  localparam logic [IW-1:0] LOSS_LAST  = IW'(LOSS_COUNT - 1);

  state_t          state;
  logic            active_q;
  logic [TW-1:0]   train_cnt;
  logic [IW-1:0]   idle_cnt;
  logic            is_pattern;
  logic            load;

  assign is_pattern = (bus.data_in_Ret == TRAIN_PATTERN);
  assign load       = (state == ACTIVE) && bus.valid_in_Ret;

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      active_q  <= 1'b0;
      train_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          state     <= TRAIN;
          train_cnt <= '0;
          idle_cnt  <= '0;
        end
        TRAIN: begin
          if (bus.valid_in_Ret) begin
            if (!is_pattern) begin
              train_cnt <= '0;
            end else if (train_cnt == TRAIN_LAST) begin
              state     <= ACTIVE;
              active_q  <= 1'b1;
              train_cnt <= '0;
              idle_cnt  <= '0;
            end else begin
              train_cnt <= train_cnt + 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (bus.valid_in_Ret) begin
            idle_cnt <= '0;
          end else if (idle_cnt == LOSS_LAST) begin
            state     <= TRAIN;
            active_q  <= 1'b0;
            train_cnt <= '0;
            idle_cnt  <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          active_q  <= 1'b0;
          train_cnt <= '0;
          idle_cnt  <= '0;
        end
      endcase
    end
  end

`ifdef RECIR_ERR_COUNT_EN
  logic       mismatch;
  logic [7:0] err_q;

  assign mismatch = (state == TRAIN) && bus.valid_in_Ret && !is_pattern;

  // Survives ACTIVE->TRAIN; only reset clears it.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L)     err_q <= 8'h00;
    else if (mismatch) err_q <= sat_inc8(err_q);
  end

  assign bus.err_count = err_q;
`else
  assign bus.err_count = 8'h00;
`endif

  assign bus.active   = active_q;
  assign bus.state_Rx = state;

  module_rx_flop #(.W(WORD_W)) u_rx_flop (
    .clk_2f  (clk_2f),
    .reset_L (reset_L),
    .load    (load),
    .data_d  (bus.data_in_Ret),
    .valid_q (bus.valid_out_Rx),
    .data_q  (bus.data_out_Rx)
  );

endmodule

// File: tb/tb_module_recir_activador.sv
// Self-checking bench for module_recir_activador: a behavioural link model is compared
// every cycle, plus directed literal checks on the key scenarios.
module tb_module_recir_activador;

  localparam logic [31:0] PAT = 32'hBCBC_BCBC;

  logic clk_2f  = 1'b0;
  logic reset_L = 1'b0;

  module_recir_activador_if bus ();

  module_recir_activador dut (
    .clk_2f  (clk_2f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk_2f = ~clk_2f;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: link either booting, hunting for a run of pattern words, or trained.
  bit          m_boot;
  bit          m_trained;
  int          m_run;
  int          m_gap;
  int          m_err;
  bit          e_valid;
  logic [31:0] e_data;

  always @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      m_boot = 1; m_trained = 0; m_run = 0; m_gap = 0; m_err = 0;
      e_valid = 0; e_data = 32'h0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (!m_trained) begin
      e_valid = 0;
      if (bus.valid_in_Ret) begin
        if (bus.data_in_Ret == PAT) begin
          m_run++;
          if (m_run == 4) begin m_trained = 1; m_run = 0; m_gap = 0; end
        end else begin
          m_run = 0;
          if (m_err < 255) m_err++;
        end
      end
    end else begin
      e_valid = bus.valid_in_Ret;
      if (bus.valid_in_Ret) begin
        e_data = bus.data_in_Ret;
        m_gap  = 0;
      end else begin
        m_gap++;
        if (m_gap == 8) begin m_trained = 0; m_run = 0; m_gap = 0; end
      end
    end
  end

  function automatic logic [7:0] exp_err();
`ifdef RECIR_ERR_COUNT_EN
    return (m_err > 255) ? 8'hFF : m_err[7:0];
`else
    return 8'h00;
`endif
  endfunction

  always @(negedge clk_2f) begin
    if (chk_en) begin
      check("m.state",  {30'b0, bus.state_Rx}, m_boot ? 32'd0 : (m_trained ? 32'd2 : 32'd1));
      check("m.active", {31'b0, bus.active},   {31'b0, m_trained});
      check("m.valid",  {31'b0, bus.valid_out_Rx}, {31'b0, e_valid});
      check("m.data",   bus.data_out_Rx, e_data);
      check("m.err",    {24'b0, bus.err_count}, {24'b0, exp_err()});
    end
  end

  task automatic send(input bit v, input logic [31:0] d);
    bus.valid_in_Ret = v;
    bus.data_in_Ret  = d;
    @(posedge clk_2f);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 32'h0);
  endtask

  task automatic release_reset();
    @(posedge clk_2f);
    #1 reset_L = 1'b1;
    send(1'b0, 32'h0);
    check("boot->train state", {30'b0, bus.state_Rx}, 32'd1);
  endtask

  initial begin
    bus.valid_in_Ret = 1'b0;
    bus.data_in_Ret  = 32'h0;
    reset_L = 1'b0;
    repeat (3) @(posedge clk_2f);
    #1;
    check("rst active", {31'b0, bus.active}, 32'd0);
    check("rst state",  {30'b0, bus.state_Rx}, 32'd0);
    check("rst valid",  {31'b0, bus.valid_out_Rx}, 32'd0);
    check("rst data",   bus.data_out_Rx, 32'h0);
    check("rst err",    {24'b0, bus.err_count}, 32'd0);
    chk_en = 1'b1;
    release_reset();

    // 1: four pattern words train the link; next word forwarded one cycle later.
    for (int i = 0; i < 3; i++) send(1'b1, PAT);
    check("t1 active after 3", {31'b0, bus.active}, 32'd0);
    send(1'b1, PAT);
    check("t1 active after 4", {31'b0, bus.active}, 32'd1);
    check("t1 state", {30'b0, bus.state_Rx}, 32'd2);
    check("t1 completing word not fwd", {31'b0, bus.valid_out_Rx}, 32'd0);
    send(1'b1, 32'h1234_5678);
    check("t1 fwd valid", {31'b0, bus.valid_out_Rx}, 32'd1);
    check("t1 fwd data", bus.data_out_Rx, 32'h1234_5678);
    send(1'b0, 32'h0);
    check("t1 gap valid", {31'b0, bus.valid_out_Rx}, 32'd0);
    check("t1 data held", bus.data_out_Rx, 32'h1234_5678);

    // 4a: seven empty cycles then a word keep the link up.
    idle(6);
    check("t4 still active", {31'b0, bus.active}, 32'd1);
    send(1'b1, 32'hAAAA_5555);
    check("t4 fwd data", bus.data_out_Rx, 32'hAAAA_5555);
    // 4b: eight empty cycles drop it.
    idle(7);
    check("t4 active at 7", {31'b0, bus.active}, 32'd1);
    idle(1);
    check("t4 loss active", {31'b0, bus.active}, 32'd0);
    check("t4 loss state", {30'b0, bus.state_Rx}, 32'd1);
    check("t4 loss valid", {31'b0, bus.valid_out_Rx}, 32'd0);

    // 2: a mismatch restarts the run and is counted.
    for (int i = 0; i < 3; i++) send(1'b1, PAT);
    send(1'b1, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) send(1'b1, PAT);
    check("t2 active after 3", {31'b0, bus.active}, 32'd0);
    send(1'b1, PAT);
    check("t2 active after 4", {31'b0, bus.active}, 32'd1);
`ifdef RECIR_ERR_COUNT_EN
    check("t2 err", {24'b0, bus.err_count}, 32'd1);
`else
    check("t2 err", {24'b0, bus.err_count}, 32'd0);
`endif

    // 3: gaps during training do not reset the run.
    idle(8);
    send(1'b1, PAT);
    idle(5);
    send(1'b1, PAT);
    send(1'b1, PAT);
    check("t3 active after 3", {31'b0, bus.active}, 32'd0);
    send(1'b1, PAT);
    check("t3 active", {31'b0, bus.active}, 32'd1);

    // 5: asynchronous reset mid-ACTIVE clears outputs without a clock edge.
    send(1'b1, 32'h0F0F_F0F0);
    check("t5 pre data", bus.data_out_Rx, 32'h0F0F_F0F0);
    #2 reset_L = 1'b0;
    #1;
    check("t5 async active", {31'b0, bus.active}, 32'd0);
    check("t5 async state",  {30'b0, bus.state_Rx}, 32'd0);
    check("t5 async valid",  {31'b0, bus.valid_out_Rx}, 32'd0);
    check("t5 async data",   bus.data_out_Rx, 32'h0);
    check("t5 async err",    {24'b0, bus.err_count}, 32'd0);
    @(posedge clk_2f);
    release_reset();
    send(1'b1, 32'h5555_0000);
    check("t5 no fwd untrained", {31'b0, bus.valid_out_Rx}, 32'd0);
    for (int i = 0; i < 4; i++) send(1'b1, PAT);
    check("t5 retrained", {31'b0, bus.active}, 32'd1);

    // 6: err_count saturates.
    idle(8);
    for (int i = 0; i < 300; i++) send(1'b1, 32'h1000_0000 + i);
`ifdef RECIR_ERR_COUNT_EN
    check("t6 err sat", {24'b0, bus.err_count}, 32'h0000_00FF);
`else
    check("t6 err off", {24'b0, bus.err_count}, 32'h0);
`endif
    check("t6 state", {30'b0, bus.state_Rx}, 32'd1);

    idle(2);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
